// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//   Synthesizable SPI/QSPI flash target. Answers Standard (0x03), Dual Output
//   (0x3B) and Quad Output (0x6B) reads plus die-select (0xC2). spi_clk, cs_n
//   and io_in are oversampled in the system_clk domain; read data is fetched
//   from a backing memory with a one-cycle read latency.
// Ports:
//   system_clk, system_reset : single clock, synchronous active-high reset
//   spi_clk, spi_cs_n, io_in : initiator pins (mode 0, spi_clk <= system_clk/8)
//   io_out, io_oe            : pad drive values and per-pin output enables
//   mem_rd_en, mem_addr      : one-cycle read strobe and byte address
//   mem_rd_data              : read data, valid one cycle after mem_rd_en
//   die_sel                  : current die, written by 0xC2
//   busy                     : high whenever the FSM is not IDLE
module qspi_flash_responder #(
  parameter int ADDR_W      = 24,
  parameter int DUMMY_CYC   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              system_clk,
  input  logic              system_reset,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              die_sel,
  output logic              busy
);

  localparam int SH_W    = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int CNT_MAX = (SH_W > DUMMY_CYC) ? SH_W : DUMMY_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DIE, IGNORE} state_t;
  typedef enum logic [1:0] {X1, X2, X4} mode_t;

  // Synchronizer chain {io_in, cs_n, spi_clk}. Deliberately not reset: a
  // reset while cs_n is held low must not manufacture a fake cs_n edge.
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]                  sync_out;
  logic                        sclk_s, cs_s;
  logic [3:0]                  io_s;

  always_ff @(posedge system_clk) begin
    sync_q[0] <= {io_in, spi_cs_n, spi_clk};
    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign sclk_s   = sync_out[0];
  assign cs_s     = sync_out[1];
  assign io_s     = sync_out[5:2];

  // Only io0 is ever sampled.
  logic unused_io;
  assign unused_io = ^io_s[3:1];

  state_t            state;
  mode_t             mode;
  logic              sclk_prev, cs_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SH_W-1:0]   shreg;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        data_buf;   // prefetched byte, captured the cycle after mem_rd_en
  logic              rd_pend;
  logic [7:0]        out_sh;     // remaining bits of the byte being presented
  logic [2:0]        grp;        // group index within the current byte

  logic              rise, fall, cs_fall;
  logic [SH_W-1:0]   shift_in;
  logic [7:0]        src;
  logic [2:0]        grp_last;

  assign rise     = sclk_s & ~sclk_prev;
  assign fall     = ~sclk_s & sclk_prev;
  assign cs_fall  = cs_prev & ~cs_s;
  assign shift_in = {shreg[SH_W-2:0], io_s[0]};
  assign busy     = (state != IDLE);

  always_comb begin
    // Group 0 of every byte comes from the prefetch buffer.
    src = (grp == 3'd0) ? data_buf : out_sh;
    case (mode)
      X1:      grp_last = 3'd7;
      X2:      grp_last = 3'd3;
      default: grp_last = 3'd1;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state     <= IDLE;
      mode      <= X1;
      io_out    <= 4'b0000;
      io_oe     <= 4'b0000;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      die_sel   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      cur_addr  <= '0;
      data_buf  <= 8'h00;
      rd_pend   <= 1'b0;
      out_sh    <= 8'h00;
      grp       <= 3'd0;
      // Track the live pin levels so no edge is seen on release.
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end else begin
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      mem_rd_en <= 1'b0;
      rd_pend   <= mem_rd_en;
      if (rd_pend) data_buf <= mem_rd_data;

      if (state != IDLE && cs_s) begin
        state <= IDLE;
        io_oe <= 4'b0000;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              case (shift_in[7:0])
                8'h03:   begin mode <= X1; state <= ADDR; end
                8'h3B:   begin mode <= X2; state <= ADDR; end
                8'h6B:   begin mode <= X4; state <= ADDR; end
                8'hC2:   state <= DIE;
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(ADDR_W-1)) begin
              bit_cnt   <= '0;
              cur_addr  <= shift_in[ADDR_W-1:0];
              mem_addr  <= shift_in[ADDR_W-1:0];
              mem_rd_en <= 1'b1;
              grp       <= 3'd0;
              state     <= (mode != X1 && DUMMY_CYC > 0) ? DUMMY : DATA;
            end
          end
          DUMMY: if (rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DUMMY_CYC-1)) begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: if (fall) begin
            case (mode)
              X1: begin
                io_out <= {2'b00, src[7], 1'b0};
                io_oe  <= 4'b0010;
                out_sh <= {src[6:0], 1'b0};
              end
              X2: begin
                io_out <= {2'b00, src[7:6]};
                io_oe  <= 4'b0011;
                out_sh <= {src[5:0], 2'b00};
              end
              default: begin
                io_out <= src[7:4];
                io_oe  <= 4'b1111;
                out_sh <= {src[3:0], 4'b0000};
              end
            endcase
            // Last group out: fetch the next byte now so it lands in
            // data_buf well before the following fall strobe.
            if (grp == grp_last) begin
              grp       <= 3'd0;
              cur_addr  <= cur_addr + ADDR_W'(1);
              mem_addr  <= cur_addr + ADDR_W'(1);
              mem_rd_en <= 1'b1;
            end else begin
              grp <= grp + 3'd1;
            end
          end
          DIE: if (rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              die_sel <= io_s[0];
              state   <= IGNORE;
            end
          end
          IGNORE: io_oe <= 4'b0000;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;
  localparam int ADDR_W      = 24;
  localparam int DUMMY_CYC   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;   // spi_clk half period in system_clk cycles

  logic              system_clk = 1'b0;
  logic              system_reset = 1'b1;
  logic              spi_clk = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic [3:0]        io_in = 4'h0;
  logic [3:0]        io_out, io_oe;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = 8'h00;
  logic              die_sel, busy;

  qspi_flash_responder #(.ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .system_clk(system_clk), .system_reset(system_reset), .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .die_sel(die_sel), .busy(busy));

  always #5 system_clk = ~system_clk;

  int vectors = 0;
  int miscompares = 0;

  // Backing memory model and log of requested addresses.
  logic [7:0]        mem [int];
  logic [ADDR_W-1:0] addr_log [$];

  function automatic logic [7:0] mem_get(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge system_clk) if (mem_rd_en) mem_rd_data <= mem_get(int'(mem_addr));
  always @(negedge system_clk) if (mem_rd_en) addr_log.push_back(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One spi_clk period: drive io0 while low, sample pads just before the
  // rising edge (as the initiator would), then rise and fall.
  task automatic xfer_cycle(input logic d0, output logic [3:0] so, output logic [3:0] soe);
    @(negedge system_clk);
    io_in = {3'($urandom), d0};
    repeat (HALF) @(negedge system_clk);
    so  = io_out;
    soe = io_oe;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge system_clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input string tag);
    logic [3:0] so, soe;
    for (int i = n - 1; i >= 0; i--) begin
      xfer_cycle(val[i], so, soe);
      chk(tag, {28'h0, soe}, 32'h0);
    end
  endtask

  task automatic start_cs();
    @(negedge system_clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge system_clk);
  endtask

  task automatic end_cs();
    repeat (HALF) @(negedge system_clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge system_clk);
  endtask

  // Full read: expected bytes come straight from mem at addr, addr+1, ...
  // (mod 2^ADDR_W); the address log must show one prefetch past the end.
  task automatic read_txn(input logic [7:0] cmd, input logic [ADDR_W-1:0] addr, input int nbytes);
    int                bpg, ndum;
    logic [3:0]        eoe, so, soe;
    logic [7:0]        byte_v;
    logic [ADDR_W-1:0] a_exp;
    case (cmd)
      8'h03:   begin bpg = 1; ndum = 0;         eoe = 4'b0010; end
      8'h3B:   begin bpg = 2; ndum = DUMMY_CYC; eoe = 4'b0011; end
      default: begin bpg = 4; ndum = DUMMY_CYC; eoe = 4'b1111; end
    endcase
    addr_log.delete();
    start_cs();
    send_bits({24'h0, cmd}, 8, "cmd_oe");
    send_bits({8'h0, addr}, ADDR_W, "addr_oe");
    if (ndum > 0) send_bits(32'h0, ndum, "dummy_oe");
    for (int b = 0; b < nbytes; b++) begin
      byte_v = 8'h00;
      for (int g = 0; g < 8 / bpg; g++) begin
        xfer_cycle(1'($urandom), so, soe);
        chk("data_oe", {28'h0, soe}, {28'h0, eoe});
        case (bpg)
          1:       byte_v = {byte_v[6:0], so[1]};
          2:       byte_v = {byte_v[5:0], so[1:0]};
          default: byte_v = {byte_v[3:0], so};
        endcase
      end
      a_exp = addr + ADDR_W'(b);
      chk("data_byte", {24'h0, byte_v}, {24'h0, mem_get(int'(a_exp))});
    end
    end_cs();
    chk("addr_count", addr_log.size(), nbytes + 1);
    for (int i = 0; i < addr_log.size() && i <= nbytes; i++) begin
      a_exp = addr + ADDR_W'(i);
      chk("mem_addr", {8'h0, addr_log[i]}, {8'h0, a_exp});
    end
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("oe_after", {28'h0, io_oe}, 32'h0);
  endtask

  task automatic die_txn(input logic [7:0] v);
    start_cs();
    send_bits(32'hC2, 8, "die_cmd_oe");
    send_bits({24'h0, v}, 8, "die_data_oe");
    end_cs();
  endtask

  initial begin
    logic [3:0]        so, soe;
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] ra;
    int                nb;
    logic [7:0]        cmds [3];
    cmds[0] = 8'h03; cmds[1] = 8'h3B; cmds[2] = 8'h6B;

    repeat (6) @(negedge system_clk);
    system_reset = 1'b0;
    @(negedge system_clk);
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_io_oe", {28'h0, io_oe}, 32'h0);
    chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_addr", {8'h0, mem_addr}, 32'h0);
    chk("rst_die", {31'h0, die_sel}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Standard, dual, quad reads
    mem[32'hBB] = 8'hAA; mem[32'hBC] = 8'hAB; mem[32'hBD] = 8'hAC; mem[32'hBE] = 8'hAD;
    read_txn(8'h03, 24'h0000BB, 4);
    mem[32'hAA] = 8'hAA; mem[32'hAB] = 8'hAB; mem[32'hAC] = 8'hAC; mem[32'hAD] = 8'hAD;
    read_txn(8'h3B, 24'h0000AA, 4);
    mem[32'hCC] = 8'hAA; mem[32'hCD] = 8'hAB; mem[32'hCE] = 8'hAC; mem[32'hCF] = 8'hAD;
    read_txn(8'h6B, 24'h0000CC, 4);

    // Die select, then a read that wraps the address space
    die_txn(8'h01);
    chk("die_set", {31'h0, die_sel}, 32'h1);
    mem[32'hFFFFFF] = 8'h5A; mem[0] = 8'hC3; mem[1] = 8'h3C;
    read_txn(8'h03, 24'hFFFFFF, 3);

    // Unsupported command: silent, no reads, die_sel untouched
    addr_log.delete();
    start_cs();
    send_bits(32'h9F, 8, "unsup_cmd_oe");
    send_bits($urandom, 32, "unsup_oe");
    end_cs();
    chk("unsup_reads", addr_log.size(), 0);
    chk("unsup_die", {31'h0, die_sel}, 32'h1);

    // Partial 0xC2 data byte must not change die_sel
    start_cs();
    send_bits(32'hC2, 8, "pdie_cmd_oe");
    send_bits(32'h0, 4, "pdie_oe");
    end_cs();
    chk("pdie_die", {31'h0, die_sel}, 32'h1);

    // Abort after 3 data bits of a standard read
    start_cs();
    send_bits(32'h03, 8, "abort_cmd_oe");
    send_bits(32'h0000BB, ADDR_W, "abort_addr_oe");
    for (int i = 0; i < 3; i++) xfer_cycle(1'b0, so, soe);
    chk("abort_busy_pre", {31'h0, busy}, 32'h1);
    chk("abort_oe_pre", {28'h0, io_oe}, 32'h2);
    @(negedge system_clk);
    spi_cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge system_clk);
    chk("abort_oe", {28'h0, io_oe}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (4 * HALF) @(negedge system_clk);
    read_txn(8'h03, 24'h0000BC, 2);

    // Reset pulse mid-address: remainder of the transaction is ignored
    start_cs();
    send_bits(32'h03, 8, "rmid_cmd_oe");
    send_bits(32'h3FF, 10, "rmid_addr_oe");
    @(negedge system_clk);
    system_reset = 1'b1;
    @(negedge system_clk);
    system_reset = 1'b0;
    @(negedge system_clk);
    chk("rmid_busy", {31'h0, busy}, 32'h0);
    chk("rmid_die", {31'h0, die_sel}, 32'h0);
    addr_log.delete();
    send_bits(32'h0000BB, 14, "rmid_rest_oe");
    send_bits($urandom, 16, "rmid_data_oe");
    chk("rmid_busy_late", {31'h0, busy}, 32'h0);
    end_cs();
    chk("rmid_reads", addr_log.size(), 0);
    read_txn(8'h6B, 24'h0000BB, 2);

    // Randomized reads against the memory model
    for (int t = 0; t < 6; t++) begin
      cmd = cmds[$urandom_range(0, 2)];
      ra  = (t == 5) ? 24'hFFFFFE : ADDR_W'($urandom);
      nb  = $urandom_range(1, 4);
      for (int i = 0; i <= nb; i++) mem[int'(ra + ADDR_W'(i))] = 8'($urandom);
      read_txn(cmd, ra, nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
